// File: rtl/mem_access.sv
// rv32i memory-access stage: issues loads/stores on a pipelined Wishbone master port,
// stalls upstream while a bus cycle is open, and registers the write-back bundle.
module mem_access #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ce,
  input  logic [4:0]            i_rd_addr,
  input  logic                  i_wr_en,
  input  logic [31:0]           i_rd,
  input  logic [31:0]           i_rs2,
  input  logic [2:0]            i_funct3,
  input  logic                  i_opcode_load,
  input  logic                  i_opcode_store,
  output logic                  o_stall,
  output logic                  o_ce,
  output logic [4:0]            o_rd_addr,
  output logic                  o_wr_en,
  output logic [31:0]           o_rd,
  output logic [31:0]           o_mem_loaded,
  output logic                  o_opcode_load,
  output logic                  o_misaligned,
  output logic                  o_bus_err,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [31:0]           o_wb_data,
  output logic [3:0]            o_wb_sel,
  input  logic                  i_wb_stall,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_err,
  input  logic [31:0]           i_wb_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  logic [1:0]            state_q, state_d;
  logic                  ce_q, ce_d;
  logic [4:0]            rd_addr_q, rd_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [31:0]           rd_q, rd_d;
  logic [31:0]           mem_loaded_q, mem_loaded_d;
  logic                  opcode_load_q, opcode_load_d;
  logic                  misaligned_q, misaligned_d;
  logic                  bus_err_q, bus_err_d;
  logic                  wb_cyc_q, wb_cyc_d;
  logic                  wb_stb_q, wb_stb_d;
  logic                  wb_we_q, wb_we_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic [3:0]            wb_sel_q, wb_sel_d;

  // Instruction context held across the bus transaction
  logic [4:0]            lat_rd_addr_q, lat_rd_addr_d;
  logic                  lat_wr_en_q, lat_wr_en_d;
  logic [31:0]           lat_rd_q, lat_rd_d;
  logic [2:0]            lat_funct3_q, lat_funct3_d;
  logic [1:0]            lat_off_q, lat_off_d;
  logic                  lat_load_q, lat_load_d;

  logic                  is_mem;
  logic                  is_store;
  logic                  addr_misaligned;
  logic [3:0]            st_sel;
  logic [31:0]           st_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           load_ext;

  // Decode of the incoming instruction: access class, alignment, store lanes
  always_comb begin
    is_mem          = i_opcode_load | i_opcode_store;
    is_store        = i_opcode_store & ~i_opcode_load;
    addr_misaligned = 1'b0;
    st_sel          = 4'b1111;
    st_data         = i_rs2;
    case (i_funct3[1:0])
      SZ_B: begin
        st_sel  = 4'b0001 << i_rd[1:0];
        st_data = {4{i_rs2[7:0]}};
      end
      SZ_H: begin
        addr_misaligned = i_rd[0];
        st_sel          = 4'b0011 << {i_rd[1], 1'b0};
        st_data         = {2{i_rs2[15:0]}};
      end
      default: begin
        addr_misaligned = |i_rd[1:0];
      end
    endcase
  end

  // Lane selection and extension of returned load data
  always_comb begin
    case (lat_off_q)
      2'd0:    ld_byte = i_wb_data[7:0];
      2'd1:    ld_byte = i_wb_data[15:8];
      2'd2:    ld_byte = i_wb_data[23:16];
      default: ld_byte = i_wb_data[31:24];
    endcase
    ld_half = lat_off_q[1] ? i_wb_data[31:16] : i_wb_data[15:0];
    case (lat_funct3_q[1:0])
      SZ_B:    load_ext = lat_funct3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    load_ext = lat_funct3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_ext = i_wb_data;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    ce_d          = 1'b0;
    misaligned_d  = 1'b0;
    bus_err_d     = 1'b0;
    rd_addr_d     = rd_addr_q;
    wr_en_d       = wr_en_q;
    rd_d          = rd_q;
    mem_loaded_d  = mem_loaded_q;
    opcode_load_d = opcode_load_q;
    wb_cyc_d      = wb_cyc_q;
    wb_stb_d      = wb_stb_q;
    wb_we_d       = wb_we_q;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    wb_sel_d      = wb_sel_q;
    lat_rd_addr_d = lat_rd_addr_q;
    lat_wr_en_d   = lat_wr_en_q;
    lat_rd_d      = lat_rd_q;
    lat_funct3_d  = lat_funct3_q;
    lat_off_d     = lat_off_q;
    lat_load_d    = lat_load_q;

    case (state_q)
      S_IDLE: begin
        if (i_ce) begin
          if (!is_mem) begin
            ce_d          = 1'b1;
            rd_addr_d     = i_rd_addr;
            wr_en_d       = i_wr_en;
            rd_d          = i_rd;
            mem_loaded_d  = 32'd0;
            opcode_load_d = 1'b0;
          end else if (addr_misaligned) begin
            ce_d          = 1'b1;
            misaligned_d  = 1'b1;
            rd_addr_d     = i_rd_addr;
            wr_en_d       = 1'b0;
            rd_d          = i_rd;
            mem_loaded_d  = 32'd0;
            opcode_load_d = 1'b0;
          end else begin
            lat_rd_addr_d = i_rd_addr;
            lat_wr_en_d   = i_wr_en;
            lat_rd_d      = i_rd;
            lat_funct3_d  = i_funct3;
            lat_off_d     = i_rd[1:0];
            lat_load_d    = ~is_store;
            wb_cyc_d      = 1'b1;
            wb_stb_d      = 1'b1;
            wb_we_d       = is_store;
            wb_addr_d     = ADDR_WIDTH'({i_rd[ADDR_WIDTH-1:2], 2'b00});
            wb_sel_d      = is_store ? st_sel : 4'b1111;
            wb_data_d     = is_store ? st_data : 32'd0;
            state_d       = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (!i_wb_stall) begin
          wb_stb_d = 1'b0;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        if (i_wb_err || i_wb_ack) begin
          wb_cyc_d  = 1'b0;
          state_d   = S_IDLE;
          ce_d      = 1'b1;
          rd_addr_d = lat_rd_addr_q;
          rd_d      = lat_rd_q;
          if (i_wb_err) begin
            wr_en_d       = 1'b0;
            bus_err_d     = 1'b1;
            mem_loaded_d  = 32'd0;
            opcode_load_d = 1'b0;
          end else if (lat_load_q) begin
            wr_en_d       = lat_wr_en_q;
            mem_loaded_d  = load_ext;
            opcode_load_d = 1'b1;
          end else begin
            wr_en_d       = 1'b0;
            opcode_load_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      ce_q          <= 1'b0;
      rd_addr_q     <= 5'd0;
      wr_en_q       <= 1'b0;
      rd_q          <= 32'd0;
      mem_loaded_q  <= 32'd0;
      opcode_load_q <= 1'b0;
      misaligned_q  <= 1'b0;
      bus_err_q     <= 1'b0;
      wb_cyc_q      <= 1'b0;
      wb_stb_q      <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= 32'd0;
      wb_sel_q      <= 4'd0;
      lat_rd_addr_q <= 5'd0;
      lat_wr_en_q   <= 1'b0;
      lat_rd_q      <= 32'd0;
      lat_funct3_q  <= 3'd0;
      lat_off_q     <= 2'd0;
      lat_load_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ce_q          <= ce_d;
      rd_addr_q     <= rd_addr_d;
      wr_en_q       <= wr_en_d;
      rd_q          <= rd_d;
      mem_loaded_q  <= mem_loaded_d;
      opcode_load_q <= opcode_load_d;
      misaligned_q  <= misaligned_d;
      bus_err_q     <= bus_err_d;
      wb_cyc_q      <= wb_cyc_d;
      wb_stb_q      <= wb_stb_d;
      wb_we_q       <= wb_we_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      wb_sel_q      <= wb_sel_d;
      lat_rd_addr_q <= lat_rd_addr_d;
      lat_wr_en_q   <= lat_wr_en_d;
      lat_rd_q      <= lat_rd_d;
      lat_funct3_q  <= lat_funct3_d;
      lat_off_q     <= lat_off_d;
      lat_load_q    <= lat_load_d;
    end
  end

  assign o_stall       = (state_q != S_IDLE);
  assign o_ce          = ce_q;
  assign o_rd_addr     = rd_addr_q;
  assign o_wr_en       = wr_en_q;
  assign o_rd          = rd_q;
  assign o_mem_loaded  = mem_loaded_q;
  assign o_opcode_load = opcode_load_q;
  assign o_misaligned  = misaligned_q;
  assign o_bus_err     = bus_err_q;
  assign o_wb_cyc      = wb_cyc_q;
  assign o_wb_stb      = wb_stb_q;
  assign o_wb_we       = wb_we_q;
  assign o_wb_addr     = wb_addr_q;
  assign o_wb_data     = wb_data_q;
  assign o_wb_sel      = wb_sel_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: drives instructions and a scripted bus slave, predicts per-cycle
// outputs from access-level rules, and compares every cycle.
module tb_mem_access;

  localparam int MAXC = 8192;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_ce;
  logic [4:0]  i_rd_addr;
  logic        i_wr_en;
  logic [31:0] i_rd;
  logic [31:0] i_rs2;
  logic [2:0]  i_funct3;
  logic        i_opcode_load;
  logic        i_opcode_store;
  logic        o_stall, o_ce, o_wr_en, o_opcode_load, o_misaligned, o_bus_err;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd, o_mem_loaded;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0] i_wb_data;

  mem_access #(.ADDR_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_rd_addr(i_rd_addr), .i_wr_en(i_wr_en),
    .i_rd(i_rd), .i_rs2(i_rs2), .i_funct3(i_funct3), .i_opcode_load(i_opcode_load),
    .i_opcode_store(i_opcode_store), .o_stall(o_stall), .o_ce(o_ce), .o_rd_addr(o_rd_addr),
    .o_wr_en(o_wr_en), .o_rd(o_rd), .o_mem_loaded(o_mem_loaded), .o_opcode_load(o_opcode_load),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic        wr_en;
    logic [31:0] rd;
    logic [31:0] ml;
    logic        ol;
    logic        mis;
    logic        berr;
    logic        chk_rd;
    logic        chk_ml;
    logic        chk_ol;
  } ret_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] data;
  } bus_t;

  bit   exp_ce    [MAXC];
  bit   exp_stall [MAXC];
  bit   exp_cyc   [MAXC];
  bit   exp_stb   [MAXC];
  bit   exp_zero  [MAXC];
  ret_t exp_ret   [MAXC];
  bus_t exp_bus   [MAXC];

  int ecount = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge i_clk) ecount <= ecount + 1;

  // Access-level reference rules
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] v;
    int sz;
    sz = size_of(f3);
    v  = w >> (8 * int'(off));
    if (sz == 1) begin
      v = v & 32'h0000_00FF;
      if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'h0000_FFFF;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_sel(input logic [31:0] addr, input logic [2:0] f3);
    int sz;
    sz = size_of(f3);
    if (sz == 4) return 4'b1111;
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] model_sdata(input logic [31:0] rs2, input logic [2:0] f3);
    int sz;
    sz = size_of(f3);
    if (sz == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
    return rs2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, ecount, act, exp);
    end
  endtask

  // Compare process: pins the model, then checks DUT outputs every cycle
  initial begin : compare
    int c;
    chk("pin_lb",   model_load(32'h80FF_0000, 2'd3, 3'd0), 32'hFFFF_FF80);
    chk("pin_lbu",  model_load(32'h80FF_0000, 2'd3, 3'd4), 32'h0000_0080);
    chk("pin_lh",   model_load(32'h80FF_0000, 2'd2, 3'd1), 32'hFFFF_80FF);
    chk("pin_lhu",  model_load(32'h80FF_0000, 2'd2, 3'd5), 32'h0000_80FF);
    chk("pin_shsel", 32'(model_sel(32'h202, 3'd1)), 32'h0000_000C);
    chk("pin_shdat", model_sdata(32'hAAAA_BEEF, 3'd1), 32'hBEEF_BEEF);
    chk("pin_sbdat", model_sdata(32'h1234_5678, 3'd0), 32'h7878_7878);
    forever begin
      @(negedge i_clk);
      c = ecount;
      if (c >= 1 && c < MAXC) begin
        chk("o_stall", 32'(o_stall), 32'(exp_stall[c]));
        chk("o_ce", 32'(o_ce), 32'(exp_ce[c]));
        chk("o_wb_cyc", 32'(o_wb_cyc), 32'(exp_cyc[c]));
        chk("o_wb_stb", 32'(o_wb_stb), 32'(exp_stb[c]));
        if (exp_stb[c]) begin
          chk("o_wb_addr", o_wb_addr, exp_bus[c].addr);
          chk("o_wb_we", 32'(o_wb_we), 32'(exp_bus[c].we));
          chk("o_wb_sel", 32'(o_wb_sel), 32'(exp_bus[c].sel));
          chk("o_wb_data", o_wb_data, exp_bus[c].data);
        end
        if (exp_ce[c]) begin
          chk("o_wr_en", 32'(o_wr_en), 32'(exp_ret[c].wr_en));
          chk("o_misaligned", 32'(o_misaligned), 32'(exp_ret[c].mis));
          chk("o_bus_err", 32'(o_bus_err), 32'(exp_ret[c].berr));
          if (exp_ret[c].chk_rd) begin
            chk("o_rd_addr", 32'(o_rd_addr), 32'(exp_ret[c].rd_addr));
            chk("o_rd", o_rd, exp_ret[c].rd);
          end
          if (exp_ret[c].chk_ml) chk("o_mem_loaded", o_mem_loaded, exp_ret[c].ml);
          if (exp_ret[c].chk_ol) chk("o_opcode_load", 32'(o_opcode_load), 32'(exp_ret[c].ol));
        end else begin
          chk("o_misaligned_idle", 32'(o_misaligned), 32'd0);
          chk("o_bus_err_idle", 32'(o_bus_err), 32'd0);
        end
        if (exp_zero[c]) begin
          chk("rst_rd_addr", 32'(o_rd_addr), 32'd0);
          chk("rst_rd", o_rd, 32'd0);
          chk("rst_mem_loaded", o_mem_loaded, 32'd0);
          chk("rst_wr_en", 32'(o_wr_en), 32'd0);
          chk("rst_opcode_load", 32'(o_opcode_load), 32'd0);
          chk("rst_wb_addr", o_wb_addr, 32'd0);
          chk("rst_wb_data", o_wb_data, 32'd0);
          chk("rst_wb_sel", 32'(o_wb_sel), 32'd0);
          chk("rst_wb_we", 32'(o_wb_we), 32'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic scramble_upstream();
    i_ce           = 1'($urandom % 2);
    i_rd_addr      = 5'($urandom);
    i_wr_en        = 1'($urandom % 2);
    i_rd           = $urandom;
    i_rs2          = $urandom;
    i_funct3       = 3'($urandom);
    i_opcode_load  = 1'($urandom % 2);
    i_opcode_store = 1'($urandom % 2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_ce       = 1'b0;
      i_wb_ack   = 1'($urandom % 2);
      i_wb_err   = 1'b0;
      i_wb_stall = 1'($urandom % 2);
      step();
    end
  endtask

  // Presents one instruction this cycle, records its expected effects and plays the bus slave
  task automatic issue(input logic [4:0] rda, input logic we, input logic [31:0] rd,
                       input logic [31:0] rs2, input logic [2:0] f3, input logic ld,
                       input logic st, input int s, input int d, input logic err,
                       input logic [31:0] rdata);
    int   n, fin, sz;
    bit   mem, mis;
    ret_t r;
    bus_t b;
    n   = ecount + 1;
    mem = ld | st;
    sz  = size_of(f3);
    mis = mem && ((rd % sz) != 0);
    i_ce = 1'b1; i_rd_addr = rda; i_wr_en = we; i_rd = rd; i_rs2 = rs2; i_funct3 = f3;
    i_opcode_load = ld; i_opcode_store = st;
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'($urandom % 2);
    r = '0;
    if (!mem) begin
      r.rd_addr = rda; r.wr_en = we; r.rd = rd;
      r.chk_rd = 1'b1; r.chk_ml = 1'b1; r.chk_ol = 1'b1;
      exp_ce[n] = 1'b1; exp_ret[n] = r;
      step();
    end else if (mis) begin
      r.mis = 1'b1;
      exp_ce[n] = 1'b1; exp_ret[n] = r;
      step();
    end else begin
      b.addr = rd & 32'hFFFF_FFFC;
      b.we   = !ld;
      b.sel  = ld ? 4'b1111 : model_sel(rd, f3);
      b.data = ld ? 32'd0 : model_sdata(rs2, f3);
      for (int c = n; c <= n + s; c++) begin exp_stb[c] = 1'b1; exp_bus[c] = b; end
      for (int c = n; c <= n + s + 1 + d; c++) begin exp_stall[c] = 1'b1; exp_cyc[c] = 1'b1; end
      fin = n + s + 2 + d;
      r.rd_addr = rda; r.rd = rd; r.chk_rd = 1'b1;
      if (err) begin
        r.berr = 1'b1; r.chk_ml = 1'b1;
      end else if (ld) begin
        r.wr_en = we; r.ml = model_load(rdata, rd[1:0], f3); r.ol = 1'b1;
        r.chk_ml = 1'b1; r.chk_ol = 1'b1;
      end else begin
        r.chk_ol = 1'b1;
      end
      exp_ce[fin] = 1'b1; exp_ret[fin] = r;
      step();
      for (int i = 0; i <= s; i++) begin
        scramble_upstream();
        i_wb_stall = (i < s);
        i_wb_ack   = 1'($urandom % 2);
        i_wb_err   = 1'($urandom % 4 == 0);
        i_wb_data  = $urandom;
        step();
      end
      for (int i = 0; i <= d; i++) begin
        scramble_upstream();
        i_wb_stall = 1'($urandom % 2);
        i_wb_ack   = (i == d) && (!err || ($urandom % 2 == 1));
        i_wb_err   = (i == d) && err;
        i_wb_data  = (i == d) ? rdata : $urandom;
        step();
      end
      i_ce = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
    end
  endtask

  // Reset lands while the bus cycle is in WAIT; the late ack must be ignored
  task automatic reset_in_wait();
    int   n;
    bus_t b;
    n = ecount + 1;
    b.addr = 32'h0000_0400; b.we = 1'b0; b.sel = 4'b1111; b.data = 32'd0;
    i_ce = 1'b1; i_rd_addr = 5'd9; i_wr_en = 1'b1; i_rd = 32'h0000_0400; i_rs2 = 32'd0;
    i_funct3 = 3'd2; i_opcode_load = 1'b1; i_opcode_store = 1'b0;
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0;
    exp_stb[n] = 1'b1; exp_bus[n] = b;
    exp_stall[n] = 1'b1; exp_cyc[n] = 1'b1;
    exp_stall[n+1] = 1'b1; exp_cyc[n+1] = 1'b1;
    for (int c = n + 2; c <= n + 6; c++) exp_zero[c] = 1'b1;
    step();
    i_ce = 1'b0; i_wb_stall = 1'b0;
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0; i_wb_ack = 1'b1; i_wb_data = 32'hDEAD_BEEF;
    step();
    i_wb_ack = 1'b0; i_wb_err = 1'b1;
    step();
    i_wb_err = 1'b0;
    idle(3);
  endtask

  initial begin : driver
    logic [31:0] addr, rs2, rdata;
    logic [2:0]  f3;
    logic        ld, st;
    int          kind, sz;
    i_rst = 1'b1; i_ce = 1'b0; i_rd_addr = '0; i_wr_en = 1'b0; i_rd = '0; i_rs2 = '0;
    i_funct3 = '0; i_opcode_load = 1'b0; i_opcode_store = 1'b0;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = '0;
    for (int c = 1; c <= 4; c++) exp_zero[c] = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    step();

    issue(5'd5, 1'b1, 32'h0000_1234, 32'd0, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0, 32'd0);
    issue(5'd7, 1'b1, 32'h0000_0103, 32'd0, 3'd0, 1'b1, 1'b0, 0, 0, 1'b0, 32'h80FF_0000);
    issue(5'd8, 1'b1, 32'h0000_0103, 32'd0, 3'd4, 1'b1, 1'b0, 0, 0, 1'b0, 32'h80FF_0000);
    issue(5'd3, 1'b0, 32'h0000_0202, 32'hAAAA_BEEF, 3'd1, 1'b0, 1'b1, 2, 0, 1'b0, 32'd0);
    issue(5'd4, 1'b1, 32'h0000_0101, 32'd0, 3'd2, 1'b1, 1'b0, 0, 0, 1'b0, 32'd0);
    issue(5'd6, 1'b1, 32'h0000_0300, 32'd0, 3'd2, 1'b1, 1'b0, 0, 1, 1'b1, 32'h1234_5678);
    issue(5'd10, 1'b1, 32'h0000_0506, 32'd0, 3'd1, 1'b1, 1'b1, 1, 2, 1'b0, 32'h8001_7FFF);
    idle(2);

    for (int it = 0; it < 300 && ecount < MAXC - 64; it++) begin
      kind  = $urandom % 3;
      rs2   = $urandom;
      rdata = $urandom;
      addr  = $urandom;
      ld    = (kind == 1);
      st    = (kind == 2) || (kind == 1 && ($urandom % 4 == 0));
      f3    = (kind == 2) ? 3'($urandom % 3) : 3'($urandom);
      sz    = size_of(f3);
      if ($urandom % 4 != 0) addr = addr & ~32'(sz - 1);
      issue(5'($urandom), 1'($urandom % 2), addr, rs2, f3, ld, st,
            $urandom % 4, $urandom % 4, 1'($urandom % 6 == 0), rdata);
      idle($urandom % 3);
    end

    reset_in_wait();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
